// File: rtl/btn_evt_pkg.sv
// Shared types for the button event controller.
//   evt_type_t : event code carried on the event port
//   state_t    : per-button press tracker state
//   id_width() : width of a button index (minimum 1 bit)
package btn_evt_pkg;

   typedef enum logic [1:0] {
      EVT_NONE   = 2'd0,
      EVT_SHORT  = 2'd1,
      EVT_LONG   = 2'd2,
      EVT_REPEAT = 2'd3
   } evt_type_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HELD  = 2'd1,
      LONGH = 2'd2
   } state_t;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/btn_press_tracker.sv
// Per-button press classifier. Emits a one-cycle strobe with an event type
// the cycle after a button edge or hold threshold.
//   clk_i, rst_ni : clock, async active-low reset
//   btn_i         : debounced button level, 1 = pressed
//   emit_o        : event strobe
//   type_o        : event type, valid with emit_o
// Optional: BTN_AUTOREPEAT_EN enables REPEAT events while held after LONG.
module btn_press_tracker
   import btn_evt_pkg::*;
#(
   parameter int LONG_CYCLES   = 8,
`ifdef BTN_AUTOREPEAT_EN
   parameter int REPEAT_CYCLES = 4,
`endif
   parameter int CNT_W         = 25
) (
   input  logic      clk_i,
   input  logic      rst_ni,
   input  logic      btn_i,
   output logic      emit_o,
   output evt_type_t type_o
);

   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`ifdef BTN_AUTOREPEAT_EN
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             btn_q;
   logic             emit_q, emit_d;
   evt_type_t        type_q, type_d;
   logic             rise, fall;

   assign rise = btn_i & ~btn_q;
   assign fall = ~btn_i & btn_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      emit_d  = 1'b0;
      type_d  = type_q;
      case (state_q)
         IDLE: begin
            if (rise) begin
               state_d = HELD;
               cnt_d   = '0;
            end
         end
         HELD: begin
            // Release is checked first so a release on the threshold cycle
            // still counts as a short press.
            if (fall) begin
               state_d = IDLE;
               cnt_d   = '0;
               emit_d  = 1'b1;
               type_d  = EVT_SHORT;
            end else if (cnt_q == LONG_LAST) begin
               state_d = LONGH;
               cnt_d   = '0;
               emit_d  = 1'b1;
               type_d  = EVT_LONG;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         LONGH: begin
            if (fall) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
`ifdef BTN_AUTOREPEAT_EN
            else if (cnt_q == REP_LAST) begin
               cnt_d  = '0;
               emit_d = 1'b1;
               type_d = EVT_REPEAT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         btn_q   <= 1'b0;
         emit_q  <= 1'b0;
         type_q  <= EVT_NONE;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         btn_q   <= btn_i;
         emit_q  <= emit_d;
         type_q  <= type_d;
      end
   end

   assign emit_o = emit_q;
   assign type_o = type_q;

endmodule

// File: rtl/button_event_ctrl.sv
// Button event controller: per-button press trackers feed one pending slot
// each; a round-robin arbiter serializes them onto a valid/ready event port.
//   Clk, Reset_n         : clock, async active-low reset
//   btn[N_BTN]           : debounced button levels
//   evt_valid/evt_ready  : event handshake
//   evt_id, evt_type     : source button and event code
//   evt_ovf / ovf_clr    : sticky dropped-event flag and its clear
// Optional: BTN_AUTOREPEAT_EN enables REPEAT events (uses REPEAT_CYCLES).
module button_event_ctrl
   import btn_evt_pkg::*;
#(
   parameter int N_BTN         = 4,
   parameter int LONG_CYCLES   = 25_000_000,
   parameter int REPEAT_CYCLES = 5_000_000,
   parameter int CNT_W         = 25,
   localparam int ID_W         = id_width(N_BTN)
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic [N_BTN-1:0] btn,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [ID_W-1:0]  evt_id,
   output evt_type_t        evt_type,
   output logic             evt_ovf,
   input  logic             ovf_clr
);

   // Largest hold count the counter must reach; the named block below only
   // elaborates when CNT_W is too narrow, making the misconfiguration visible
   // in the hierarchy.
   localparam longint MAX_CYC = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
   if ((MAX_CYC >> CNT_W) != 0) begin : g_cnt_w_too_small
   end

   logic      [N_BTN-1:0] emit;
   evt_type_t [N_BTN-1:0] emit_type;

   for (genvar i = 0; i < N_BTN; i++) begin : g_trk
      btn_press_tracker #(
         .LONG_CYCLES  (LONG_CYCLES),
`ifdef BTN_AUTOREPEAT_EN
         .REPEAT_CYCLES(REPEAT_CYCLES),
`endif
         .CNT_W        (CNT_W)
      ) u_trk (
         .clk_i (Clk),
         .rst_ni(Reset_n),
         .btn_i (btn[i]),
         .emit_o(emit[i]),
         .type_o(emit_type[i])
      );
   end

   logic      [N_BTN-1:0] pend_q, pend_d;
   evt_type_t [N_BTN-1:0] pend_type_q, pend_type_d;
   logic                  evt_valid_q;
   logic      [ID_W-1:0]  evt_id_q, rr_ptr_q, rr_next;
   evt_type_t             evt_type_q, grant_type;
   logic                  ovf_q, drop, free, grant_any;
   logic      [ID_W-1:0]  grant_id, idx;
   logic      [N_BTN-1:0] grant_oh;
   int                    tmp;

   assign free = ~evt_valid_q | evt_ready;

   // A fresh strobe counts as a request too, so an idle button reaches the
   // port two cycles after its edge instead of three.
   always_comb begin
      grant_any = 1'b0;
      grant_id  = '0;
      grant_oh  = '0;
      idx       = '0;
      tmp       = 0;
      if (free) begin
         for (int k = 0; k < N_BTN; k++) begin
            tmp = int'(rr_ptr_q) + k;
            if (tmp >= N_BTN) tmp = tmp - N_BTN;
            idx = ID_W'(tmp);
            if (!grant_any && (pend_q[idx] || emit[idx])) begin
               grant_any     = 1'b1;
               grant_id      = idx;
               grant_oh[idx] = 1'b1;
            end
         end
      end
   end

   // The slot holds the older event, so it goes out before a same-cycle strobe.
   assign grant_type = pend_q[grant_id] ? pend_type_q[grant_id] : emit_type[grant_id];
   assign rr_next    = (grant_id == ID_W'(N_BTN - 1)) ? '0 : grant_id + 1'b1;

   always_comb begin
      pend_d      = pend_q;
      pend_type_d = pend_type_q;
      drop        = 1'b0;
      for (int k = 0; k < N_BTN; k++) begin
         if (grant_oh[k]) begin
            // Granted: a strobe either bypassed an empty slot or refills it.
            pend_d[k] = pend_q[k] & emit[k];
            if (emit[k]) pend_type_d[k] = emit_type[k];
         end else if (emit[k]) begin
            if (pend_q[k]) begin
               drop = 1'b1;
            end else begin
               pend_d[k]      = 1'b1;
               pend_type_d[k] = emit_type[k];
            end
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         pend_q      <= '0;
         pend_type_q <= {N_BTN{EVT_NONE}};
         evt_valid_q <= 1'b0;
         evt_id_q    <= '0;
         evt_type_q  <= EVT_NONE;
         rr_ptr_q    <= '0;
         ovf_q       <= 1'b0;
      end else begin
         pend_q      <= pend_d;
         pend_type_q <= pend_type_d;
         if (free) begin
            evt_valid_q <= grant_any;
            if (grant_any) begin
               evt_id_q   <= grant_id;
               evt_type_q <= grant_type;
               rr_ptr_q   <= rr_next;
            end
         end
         if (drop)         ovf_q <= 1'b1;
         else if (ovf_clr) ovf_q <= 1'b0;
      end
   end

   assign evt_valid = evt_valid_q;
   assign evt_id    = evt_id_q;
   assign evt_type  = evt_type_q;
   assign evt_ovf   = ovf_q;

endmodule

// File: tb/tb_button_event_ctrl.sv
module tb_button_event_ctrl;
   import btn_evt_pkg::*;

   localparam int NB = 4;
   localparam int LC = 8;
   localparam int RC = 4;

   logic          Clk = 1'b0;
   logic          Reset_n = 1'b0;
   logic [NB-1:0] btn = '0;
   logic          evt_ready = 1'b1;
   logic          ovf_clr = 1'b0;
   logic          evt_valid, evt_ovf;
   logic [1:0]    evt_id;
   evt_type_t     evt_type;

   int checks = 0;
   int errors = 0;

   typedef struct { int id; evt_type_t t; } exp_t;
   typedef struct { logic [NB-1:0] mask; int hold; evt_type_t t; } vec_t;

   exp_t sb[$];
   int   tb_rr = 0;
   vec_t vt[8];

   always #5 Clk = ~Clk;

   button_event_ctrl #(
      .N_BTN(NB), .LONG_CYCLES(LC), .REPEAT_CYCLES(RC), .CNT_W(5)
   ) dut (
      .Clk(Clk), .Reset_n(Reset_n), .btn(btn),
      .evt_valid(evt_valid), .evt_ready(evt_ready),
      .evt_id(evt_id), .evt_type(evt_type),
      .evt_ovf(evt_ovf), .ovf_clr(ovf_clr)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   // Expected SHORT/LONG events for buttons in m, in round-robin order.
   task automatic push_mask(input logic [NB-1:0] m, input evt_type_t t, input int nrep);
      int start, i;
      exp_t e;
      start = tb_rr;
      for (int k = 0; k < NB; k++) begin
         i = (start + k) % NB;
         if (m[i]) begin
            e.id = i; e.t = t; sb.push_back(e);
            for (int r = 0; r < nrep; r++) begin
               e.t = EVT_REPEAT; sb.push_back(e);
            end
            tb_rr = (i + 1) % NB;
         end
      end
   endtask

   function automatic int reps(input int hold);
`ifdef BTN_AUTOREPEAT_EN
      return (hold > LC) ? (hold - LC - 1) / RC : 0;
`else
      return (hold < 0) ? 1 : 0;
`endif
   endfunction

   task automatic wait_valid(input string name, input int budget);
      int n = 0;
      while (!evt_valid && n < budget) begin
         tick(1);
         n++;
      end
      chk(name, int'(evt_valid), 1);
   endtask

   // Scoreboard: each handshake pops one expected event.
   always @(negedge Clk) begin : mon
      exp_t e;
      if (Reset_n && evt_valid && evt_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got id %0d type %0d, none expected", evt_id, evt_type);
         end else begin
            e = sb.pop_front();
            chk("evt_id", int'(evt_id), e.id);
            chk("evt_type", int'(evt_type), int'(e.t));
         end
      end
   end

   initial begin
      int hid, htype;
      vt[0] = '{4'b0010, 3,  EVT_SHORT};
      vt[1] = '{4'b1011, 2,  EVT_SHORT};
      vt[2] = '{4'b0100, 20, EVT_LONG};
      vt[3] = '{4'b1011, 2,  EVT_SHORT};
      vt[4] = '{4'b0111, 2,  EVT_SHORT};
      vt[5] = '{4'b1111, 1,  EVT_SHORT};
      vt[6] = '{4'b0001, 8,  EVT_SHORT};
      vt[7] = '{4'b0001, 9,  EVT_LONG};

      // Reset state
      tick(2);
      chk("rst_valid", int'(evt_valid), 0);
      chk("rst_id", int'(evt_id), 0);
      chk("rst_type", int'(evt_type), int'(EVT_NONE));
      chk("rst_ovf", int'(evt_ovf), 0);
      Reset_n = 1'b1;
      tick(2);

      // Short press timing: valid two cycles after the fall is seen
      btn[1] = 1'b1;
      push_mask(4'b0010, EVT_SHORT, 0);
      tick(3);
      btn = '0;
      tick(1);
      chk("short_lat_early", int'(evt_valid), 0);
      tick(1);
      chk("short_lat_valid", int'(evt_valid), 1);
      tick(6);

      // Long press timing: LONG strobe 8 cycles after rise, +1 to output
      btn[2] = 1'b1;
      push_mask(4'b0100, EVT_LONG, reps(20));
      tick(9);
      chk("long_lat_early", int'(evt_valid), 0);
      tick(1);
      chk("long_lat_valid", int'(evt_valid), 1);
      tick(10);
      btn = '0;
      tick(10);
      chk("long_drain", sb.size(), 0);

      // Table-driven vectors
      for (int v = 0; v < 8; v++) begin
         btn = vt[v].mask;
         push_mask(vt[v].mask, vt[v].t, reps(vt[v].hold));
         tick(vt[v].hold);
         btn = '0;
         tick(12);
         chk($sformatf("vec%0d_drain", v), sb.size(), 0);
      end

      // Backpressure: output stable while not ready
      evt_ready = 1'b0;
      btn[2] = 1'b1;
      push_mask(4'b0100, EVT_SHORT, 0);
      tick(2);
      btn = '0;
      wait_valid("bp_wait", 10);
      hid = int'(evt_id);
      htype = int'(evt_type);
      chk("bp_id", hid, 2);
      for (int c = 0; c < 10; c++) begin
         tick(1);
         chk("bp_valid_hold", int'(evt_valid), 1);
         chk("bp_id_hold", int'(evt_id), hid);
         chk("bp_type_hold", int'(evt_type), htype);
      end
      evt_ready = 1'b1;
      tick(1);
      chk("bp_consumed", int'(evt_valid), 0);
      chk("bp_drain", sb.size(), 0);

      // Overflow: output register and slot full, third press dropped
      evt_ready = 1'b0;
      for (int p = 0; p < 3; p++) begin
         if (p == 2) chk("ovf_before", int'(evt_ovf), 0);
         btn[0] = 1'b1;
         tick(2);
         btn = '0;
         tick(4);
      end
      chk("ovf_set", int'(evt_ovf), 1);
      push_mask(4'b0001, EVT_SHORT, 0);
      push_mask(4'b0001, EVT_SHORT, 0);
      evt_ready = 1'b1;
      tick(4);
      chk("ovf_sticky", int'(evt_ovf), 1);
      chk("ovf_drain", sb.size(), 0);
      ovf_clr = 1'b1;
      tick(1);
      ovf_clr = 1'b0;
      chk("ovf_clr", int'(evt_ovf), 0);

      // Reset mid-hold with an event parked on the port
      evt_ready = 1'b0;
      btn[2] = 1'b1;
      tick(2);
      btn = '0;
      wait_valid("rst_pre_wait", 10);
      btn[3] = 1'b1;
      tick(6);
      Reset_n = 1'b0;
      #1;
      chk("rstm_valid", int'(evt_valid), 0);
      chk("rstm_id", int'(evt_id), 0);
      chk("rstm_type", int'(evt_type), int'(EVT_NONE));
      chk("rstm_ovf", int'(evt_ovf), 0);
      sb.delete();
      tb_rr = 0;
      tick(2);
      Reset_n = 1'b1;
      evt_ready = 1'b1;
      push_mask(4'b1000, EVT_LONG, 0);
      tick(9);
      chk("rstm_long_early", int'(evt_valid), 0);
      tick(1);
      chk("rstm_long_valid", int'(evt_valid), 1);
      tick(1);
      btn = '0;
      tick(6);
      chk("rstm_drain", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within bound");
      $fatal(1, "timeout");
   end

endmodule
